// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready request -> APB SETUP/ACCESS requester.
// Latency: request accepted at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3 + wait states.
// Backpressure: req_ready only in IDLE; a response is held in RESP until rsp_ready.
// Optional: define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // request stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // A zero timeout would abort before the slave could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                  state_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    tmo_hit;

`ifdef APB_MST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;

  // This waiting cycle would bring the count to TIMEOUT_CYCLES: abort at this edge.
  assign tmo_hit = (state_q == S_ACCESS) && !PREADY &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter is zero on ACCESS entry and advances on every wait-state cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACCESS && !PREADY && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Wait-state counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the timeout the bridge waits on PREADY indefinitely.
  assign tmo_hit = 1'b0;
`endif

  // Transfer FSM; every APB and response output is a register updated here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is the handshake.
          if (req_valid) begin
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_err_q   <= PSLVERR;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_hit) begin
            // Abandoned transfer: report an error with no data.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          // rsp_rdata/rsp_err simply hold; only the valid flag drops on handshake.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Acceptance is decoded from state only, never from the request inputs.
  assign req_ready = (state_q == S_IDLE);

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: randomized transfers against a memory-backed slave model.
// All driving and sampling happens on the falling edge of PCLK.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int checks   = 0;
  int failures = 0;

  // Slave memory: holds the last successfully written word per address.
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // Observations of the most recent transfer (cycle 0 = the request handshake edge).
  int            r_accepted, r_setup_cyc, r_first_acc, r_acc_cnt, r_rsp_cyc, r_end_cyc;
  int            r_bus_bad, r_hold_bad;
  logic [DW-1:0] r_rdata;
  logic          r_rerr;

  // Drives one request and plays the slave; records what it saw, compares nothing.
  // Must be entered just after a falling edge; returns just after one.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic serr, input int hold, input int limit);
    int cyc  = 0;
    int rise = -1;
    r_accepted = (req_ready === 1'b1) ? 1 : 0;
    r_setup_cyc = -1; r_first_acc = -1; r_acc_cnt = 0; r_rsp_cyc = -1; r_end_cyc = -1;
    r_bus_bad = 0; r_hold_bad = 0; r_rdata = '0; r_rerr = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    while (r_end_cyc < 0 && cyc < limit) begin
      @(negedge PCLK);
      cyc++;
      // While the bridge is busy, throw junk at the request port; it must be ignored.
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (PSEL === 1'b1) begin
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) r_bus_bad++;
        if (req_ready !== 1'b0) r_bus_bad++;
      end
      if (PSEL === 1'b1 && PENABLE === 1'b0 && r_setup_cyc < 0) r_setup_cyc = cyc;
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        if (r_first_acc < 0) r_first_acc = cyc;
        r_acc_cnt++;
        if (r_acc_cnt > waits) begin
          PREADY  = 1'b1;
          PSLVERR = serr;
          PRDATA  = wr ? $urandom : model_rd(addr);
          if (wr && !serr) mem[addr] = wdata;
        end else begin
          PREADY = 1'b0;
        end
      end
      if (rsp_valid === 1'b1) begin
        if (r_rsp_cyc < 0) begin
          r_rsp_cyc = cyc; r_rdata = rsp_rdata; r_rerr = rsp_err;
        end else if (rsp_rdata !== r_rdata || rsp_err !== r_rerr || req_ready !== 1'b0) begin
          r_hold_bad++;
        end
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) r_hold_bad++;
        if (cyc - r_rsp_cyc >= hold) begin
          if (rise < 0) rise = cyc;
          rsp_ready = 1'b1;
        end
      end else if (r_rsp_cyc >= 0) begin
        r_end_cyc = cyc;
        if (cyc - rise != 1) r_hold_bad++;
        if (req_ready !== 1'b1) r_hold_bad++;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
    end
    checks++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
      failures++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", PADDR, PWDATA, rsp_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_basic();
    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, 50);
    checks++;
    if (r_accepted != 1 || r_setup_cyc != 1 || r_first_acc != 2) begin
      failures++; $display("FAIL wr_phases: got acc=%0d setup=%0d access=%0d want 1/1/2", r_accepted, r_setup_cyc, r_first_acc);
    end
    checks++;
    if (r_rsp_cyc != 3) begin
      failures++; $display("FAIL wr_latency: got %0d want 3", r_rsp_cyc);
    end
    checks++;
    if (r_rerr !== 1'b0 || r_rdata !== '0) begin
      failures++; $display("FAIL wr_rsp: got err=%b rdata=%h want 0/0", r_rerr, r_rdata);
    end
    checks++;
    if (r_bus_bad != 0 || PADDR !== 32'h10 || PWRITE !== 1'b1) begin
      failures++; $display("FAIL wr_bus_stable: got bad=%0d paddr=%h pwrite=%b want 0/10/1", r_bus_bad, PADDR, PWRITE);
    end
  endtask

  task automatic test_read_wait();
    logic [DW-1:0] exp_rd;
    exp_rd = model_rd(32'h10);
    run_xfer(1'b0, 32'h10, 32'h0, 2, 1'b0, 0, 50);
    checks++;
    if (r_acc_cnt != 3 || r_rsp_cyc != 5) begin
      failures++; $display("FAIL rd_wait_timing: got access=%0d rsp_cyc=%0d want 3/5", r_acc_cnt, r_rsp_cyc);
    end
    checks++;
    if (r_rdata !== exp_rd || exp_rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_wait_data: got %h want DEADBEEF", r_rdata);
    end
  endtask

  task automatic test_slverr();
    logic [DW-1:0] exp_rd;
    exp_rd = model_rd(32'h3FC);
    run_xfer(1'b0, 32'h3FC, 32'h0, 1, 1'b1, 0, 50);
    checks++;
    if (r_rerr !== 1'b1 || r_rdata !== exp_rd) begin
      failures++; $display("FAIL slverr_rsp: got err=%b rdata=%h want 1/%h", r_rerr, r_rdata, exp_rd);
    end
    run_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, 50);
    checks++;
    if (r_rerr !== 1'b0 || r_rsp_cyc != 3 || r_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL slverr_recover: got err=%b cyc=%0d rdata=%h want 0/3/DEADBEEF", r_rerr, r_rsp_cyc, r_rdata);
    end
  endtask

  task automatic test_rsp_backpressure();
    logic [DW-1:0] exp_rd;
    exp_rd = model_rd(32'h10);
    run_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 5, 50);
    checks++;
    if (r_hold_bad != 0 || r_rdata !== exp_rd) begin
      failures++; $display("FAIL bp_stable: got bad=%0d rdata=%h want 0/%h", r_hold_bad, r_rdata, exp_rd);
    end
    checks++;
    if (r_end_cyc != r_rsp_cyc + 6) begin
      failures++; $display("FAIL bp_idle_cycle: got %0d want %0d", r_end_cyc, r_rsp_cyc + 6);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_rd;
    int bad = 0;
    exp_rd = model_rd(32'h20);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = $urandom; PREADY = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_access: got psel=%b penable=%b want 1/1", PSEL, PENABLE);
    end
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== '0) begin
      failures++; $display("FAIL rstmid_async: got psel=%b penable=%b paddr=%h want 0/0/0", PSEL, PENABLE, PADDR);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad);
    end
    run_xfer(1'b0, 32'h20, 32'h0, 1, 1'b0, 0, 50);
    checks++;
    if (r_rsp_cyc != 4 || r_rerr !== 1'b0 || r_rdata !== exp_rd) begin
      failures++; $display("FAIL rstmid_fresh_read: got cyc=%0d err=%b rdata=%h want 4/0/%h", r_rsp_cyc, r_rerr, r_rdata, exp_rd);
    end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h40, 32'h0, 1000, 1'b0, 0, 130);
`ifdef APB_MST_TIMEOUT_EN
    checks++;
    if (r_rsp_cyc != 2 + TO || r_acc_cnt != TO) begin
      failures++; $display("FAIL timeout_cycles: got rsp=%0d access=%0d want %0d/%0d", r_rsp_cyc, r_acc_cnt, 2 + TO, TO);
    end
    checks++;
    if (r_rerr !== 1'b1 || r_rdata !== '0 || r_end_cyc < 0) begin
      failures++; $display("FAIL timeout_rsp: got err=%b rdata=%h end=%0d want 1/0/done", r_rerr, r_rdata, r_end_cyc);
    end
`else
    checks++;
    if (r_rsp_cyc != -1 || r_acc_cnt < 100) begin
      failures++; $display("FAIL no_timeout_wait: got rsp=%0d access=%0d want -1/>=100", r_rsp_cyc, r_acc_cnt);
    end
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      failures++; $display("FAIL no_timeout_still_access: got psel=%b penable=%b want 1/1", PSEL, PENABLE);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
`endif
  endtask

  task automatic test_back_to_back();
    logic          wr, serr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, exp_rd;
    int            waits, hold;
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom);
      addr  = {26'h0, 4'($urandom), 2'b00};
      wdata = $urandom;
      waits = $urandom_range(0, 3);
      serr  = ($urandom_range(0, 7) == 0);
      hold  = $urandom_range(0, 2);
      exp_rd = wr ? '0 : model_rd(addr);
      run_xfer(wr, addr, wdata, waits, serr, hold, 60);
      checks++;
      if (r_rsp_cyc != 3 + waits || r_acc_cnt != waits + 1 || r_setup_cyc != 1) begin
        failures++; $display("FAIL b2b_timing[%0d]: got rsp=%0d access=%0d setup=%0d want %0d/%0d/1", n, r_rsp_cyc, r_acc_cnt, r_setup_cyc, 3 + waits, waits + 1);
      end
      checks++;
      if (r_rdata !== exp_rd || r_rerr !== serr) begin
        failures++; $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b want %h/%b", n, r_rdata, r_rerr, exp_rd, serr);
      end
      checks++;
      if (r_bus_bad != 0 || r_hold_bad != 0 || r_end_cyc != r_rsp_cyc + hold + 1) begin
        failures++; $display("FAIL b2b_protocol[%0d]: got bus=%0d hold=%0d end=%0d want 0/0/%0d", n, r_bus_bad, r_hold_bad, r_end_cyc, r_rsp_cyc + hold + 1);
      end
    end
    // Zero wait states and an always-ready consumer: a new request every 4 cycles.
    for (int n = 0; n < 2; n++) begin
      run_xfer(1'b1, 32'h80 + 32'(n * 4), $urandom, 0, 1'b0, 0, 20);
      checks++;
      if (r_end_cyc != 4 || r_accepted != 1) begin
        failures++; $display("FAIL throughput[%0d]: got period=%0d accepted=%0d want 4/1", n, r_end_cyc, r_accepted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_rsp_backpressure();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
